// File: rtl/sparc_ram_loader.sv
// sparc_ram_loader: byte-stream LOAD/DUMP engine on the SPARC RAM port.
// Optional MOC watchdog and timeout port: define SPARC_RAM_LOADER_TIMEOUT_EN.
module sparc_ram_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
  ,
  parameter int MOC_TIMEOUT = 15
`endif
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   dump_len,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_mov,
  output logic              ram_rw,
  output logic [1:0]        ram_type,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_moc,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   count
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L_WAIT,
    S_L_MOV,
    S_L_REL,
    S_D_MOV,
    S_D_REL,
    S_D_OUT,
    S_ABORT
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        obyte_q, obyte_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(MOC_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MOC_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              tout_q, tout_d;
`endif

  // Next-state and datapath updates for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    obyte_d = obyte_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
    tmo_d   = tmo_q;
    tout_d  = tout_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d = S_L_WAIT;
          addr_d  = base_addr;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
        end else if (start_dump) begin
          addr_d  = base_addr;
          len_d   = dump_len;
          count_d = '0;
          ovf_d   = 1'b0;
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
          tout_d  = 1'b0;
`endif
          if (dump_len != '0) begin
            state_d = S_D_MOV;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_L_WAIT: begin
        if (in_valid) begin
          wdata_d = in_byte;
          last_d  = in_last;
          state_d = S_L_MOV;
        end
      end
      S_L_MOV: begin
        if (ram_moc) begin
          state_d = S_L_REL;
        end
      end
      S_L_REL: begin
        if (!ram_moc) begin
          count_d = count_q + CNT_ONE;
          if (last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (addr_q == LAST_ADDR) begin
            state_d = S_IDLE;
            ovf_d   = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_L_WAIT;
          end
        end
      end
      S_D_MOV: begin
        if (ram_moc) begin
          obyte_d = ram_rdata;
          state_d = S_D_REL;
        end
      end
      S_D_REL: begin
        if (!ram_moc) begin
          state_d = S_D_OUT;
        end
      end
      S_D_OUT: begin
        if (out_ready) begin
          count_d = count_q + CNT_ONE;
          if (count_q + CNT_ONE == len_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
            state_d = S_D_MOV;
          end
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
    // Watchdog: any RAM handshake state held too long is abandoned.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q inside {S_L_MOV, S_L_REL, S_D_MOV, S_D_REL}) begin
      if (tmo_q == TMO_LAST) begin
        state_d = S_ABORT;
        tout_d  = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TMO_ONE;
      end
    end
`endif
  end

  // Sequencer state and status flags.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      last_q  <= last_d;
      len_q   <= len_d;
    end
  end

  // Address and data holding registers facing the RAM and the stream.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      addr_q  <= '0;
      wdata_q <= '0;
      obyte_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      obyte_q <= obyte_d;
    end
  end

`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
  // MOC watchdog counter and sticky timeout flag.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      tmo_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      tout_q <= tout_d;
    end
  end

  assign timeout = tout_q;
`endif

  // RAM strobes decode straight from the state so reset drops them at once.
  assign ram_mov   = (state_q == S_L_MOV) || (state_q == S_D_MOV);
  assign ram_rw    = (state_q == S_D_MOV);
  assign ram_type  = 2'b00;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign in_ready  = (state_q == S_L_WAIT);
  assign out_valid = (state_q == S_D_OUT);
  assign out_byte  = obyte_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_sparc_ram_loader.sv
// tb_sparc_ram_loader: directed + random LOAD/DUMP against a RAM model.
// Define SPARC_RAM_LOADER_TIMEOUT_EN to also exercise the MOC watchdog.
module tb_sparc_ram_loader;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              Clk = 1'b0;
  logic              Clr = 1'b0;
  logic              start_load = 1'b0;
  logic              start_dump = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   dump_len = '0;
  logic [7:0]        in_byte = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_mov;
  logic              ram_rw;
  logic [1:0]        ram_type;
  logic [7:0]        ram_rdata;
  logic              ram_moc;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   count;
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
  logic              timeout;
`endif

  sparc_ram_loader dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .start_load(start_load),
    .start_dump(start_dump),
    .base_addr (base_addr),
    .dump_len  (dump_len),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_mov   (ram_mov),
    .ram_rw    (ram_rw),
    .ram_type  (ram_type),
    .ram_rdata (ram_rdata),
    .ram_moc   (ram_moc),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .count     (count)
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  bit         mem_ready;
  int         lat;
  int         moc_lat = 2;
  bit         moc_en = 1'b1;
  int         done_cnt = 0;
  int         mov_cnt = 0;
  int         type_err = 0;

  // External RAM: MOC after moc_lat extra cycles, released when MOV drops.
  always @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      ram_moc <= 1'b0;
      lat <= 0;
      if (!mem_ready) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 7 + 3);
        ram_rdata <= 8'h00;
        mem_ready <= 1'b1;
      end
    end else if (!ram_mov) begin
      ram_moc <= 1'b0;
      lat <= 0;
    end else if (!ram_moc && moc_en) begin
      if (lat >= moc_lat) begin
        ram_moc <= 1'b1;
        if (ram_rw) ram_rdata <= mem[ram_addr];
        else mem[ram_addr] <= ram_wdata;
      end else begin
        lat <= lat + 1;
      end
    end
  end

  // Event monitors sampled mid-cycle.
  always @(negedge Clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (ram_mov) mov_cnt <= mov_cnt + 1;
    if (ram_type !== 2'b00) type_err <= type_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last,
                           output bit ok);
    int k;
    in_byte  = d;
    in_last  = last;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge Clk);
      k++;
    end
    ok = in_ready;
    check("in_ready_wait", 32'(in_ready), 32'd1);
    if (ok) @(negedge Clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_load(input int b, input int n, input logic [7:0] q[$]);
    int acc, dc0, k, hi, merr;
    bit ok;
    acc = (n < DEPTH - b) ? n : DEPTH - b;
    dc0 = done_cnt;
    base_addr  = ADDR_W'(b);
    start_load = 1'b1;
    @(negedge Clk);
    start_load = 1'b0;
    for (int i = 0; i < acc; i++) begin
      push_byte(q[i], (i == n - 1), ok);
      if (!ok) break;
      ref_mem[b + i] = q[i];
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end
    k = 0;
    while (busy && k < 200) begin
      @(negedge Clk);
      k++;
    end
    check("load_idle", 32'(busy), 32'd0);
    @(negedge Clk);
    check("load_count", 32'(count), 32'(acc));
    check("load_ovf", 32'(overflow), 32'(n > acc));
    check("load_done", 32'(done_cnt - dc0), (n > acc) ? 32'd0 : 32'd1);
    merr = 0;
    for (int i = 0; i < acc; i++)
      if (mem[b + i] !== ref_mem[b + i]) merr++;
    check("load_mem", 32'(merr), 32'd0);
    if (n > acc) begin
      hi = 0;
      in_byte  = q[acc];
      in_valid = 1'b1;
      repeat (6) begin
        @(negedge Clk);
        if (in_ready) hi++;
      end
      in_valid = 1'b0;
      check("ovf_in_ready_low", 32'(hi), 32'd0);
    end
  endtask

  task automatic run_dump(input int b, input int n, input int mode);
    int got, k, mv0;
    bit held_v, t;
    logic [7:0] held_b;
    mv0 = mov_cnt;
    base_addr  = ADDR_W'(b);
    dump_len   = (ADDR_W + 1)'(n);
    start_dump = 1'b1;
    @(negedge Clk);
    start_dump = 1'b0;
    check("ovf_clear", 32'(overflow), 32'd0);
    if (n == 0) begin
      check("dump0_done", 32'(done), 32'd1);
      check("dump0_busy", 32'(busy), 32'd0);
      @(negedge Clk);
      check("dump0_pulse", 32'(done), 32'd0);
      @(negedge Clk);
      check("dump0_nomov", 32'(mov_cnt - mv0), 32'd0);
      return;
    end
    got = 0;
    k = 0;
    held_v = 1'b0;
    held_b = '0;
    t = 1'b1;
    while (got < n && k < 4000) begin
      if (held_v) begin
        check("dump_hold", 32'({out_valid, out_byte}), 32'({1'b1, held_b}));
        held_v = 1'b0;
      end
      if (mode == 1) begin
        out_ready = t;
        t = ~t;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (out_valid) begin
        if (out_ready) begin
          check("dump_byte", 32'(out_byte), 32'(ref_mem[(b + got) % DEPTH]));
          got++;
        end else begin
          held_v = 1'b1;
          held_b = out_byte;
        end
      end
      @(negedge Clk);
      k++;
    end
    out_ready = 1'b0;
    check("dump_got", 32'(got), 32'(n));
    check("dump_done", 32'(done), 32'd1);
    check("dump_idle", 32'(busy), 32'd0);
    check("dump_count", 32'(count), 32'(n));
    @(negedge Clk);
    check("dump_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    int b, n, k;
    bit ok;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 7 + 3);

    #2 Clr = 1'b1;
    #1;
    check("rst_flags",
          32'({busy, done, in_ready, out_valid, ram_mov, ram_rw, overflow}),
          32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_obyte", 32'(out_byte), 32'd0);
    check("rst_type", 32'(ram_type), 32'd0);
`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
    check("rst_timeout", 32'(timeout), 32'd0);
`endif
    repeat (2) @(negedge Clk);
    Clr = 1'b0;
    @(negedge Clk);

    // Reset while a write is stuck in L_MOV.
    moc_lat = 1;
    base_addr  = 9'd100;
    start_load = 1'b1;
    @(negedge Clk);
    start_load = 1'b0;
    push_byte(8'hA5, 1'b0, ok);
    ref_mem[100] = 8'hA5;
    push_byte(8'h5A, 1'b0, ok);
    ref_mem[101] = 8'h5A;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge Clk);
      k++;
    end
    moc_en = 1'b0;
    push_byte(8'h3C, 1'b0, ok);
    repeat (2) @(negedge Clk);
    check("pre_rst_mov", 32'(ram_mov), 32'd1);
    check("pre_rst_count", 32'(count), 32'd2);
    #1 Clr = 1'b1;
    #1;
    check("rst_async_mov", 32'(ram_mov), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    check("rst_async_count", 32'(count), 32'd0);
    @(negedge Clk);
    Clr = 1'b0;
    moc_en = 1'b1;
    @(negedge Clk);

    // Directed load of three bytes at address 0.
    moc_lat = 2;
    q = '{8'h11, 8'h22, 8'h33};
    run_load(0, 3, q);

    // Load running off the top of RAM.
    q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    run_load(510, 4, q);

    // Dump back with out_ready alternating.
    run_dump(0, 3, 1);

    // Zero-length dump.
    run_dump(7, 0, 0);

    // Random loads and dumps with varying RAM latency.
    for (int it = 0; it < 8; it++) begin
      b = (it % 3 == 0) ? int'($urandom_range(DEPTH - 6, DEPTH - 1))
                        : int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, 10));
      moc_lat = int'($urandom_range(0, 3));
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_load(b, n, q);
      moc_lat = int'($urandom_range(0, 3));
      run_dump(int'($urandom_range(0, DEPTH - 1)),
               int'($urandom_range(1, 12)), 0);
    end

    // Dump wrapping past the last address.
    run_dump(505, 12, 0);

`ifdef SPARC_RAM_LOADER_TIMEOUT_EN
    // RAM never answers: watchdog must abort the write.
    begin
      int c, dc0;
      dc0 = done_cnt;
      moc_en = 1'b0;
      base_addr  = 9'd200;
      start_load = 1'b1;
      @(negedge Clk);
      start_load = 1'b0;
      push_byte(8'h77, 1'b1, ok);
      c = 0;
      while (ram_mov && c < 100) begin
        c++;
        @(negedge Clk);
      end
      check("tmo_cycles", 32'(c), 32'd15);
      check("tmo_flag", 32'(timeout), 32'd1);
      check("tmo_mov_low", 32'(ram_mov), 32'd0);
      @(negedge Clk);
      check("tmo_idle", 32'(busy), 32'd0);
      @(negedge Clk);
      check("tmo_no_done", 32'(done_cnt - dc0), 32'd0);
      moc_en = 1'b1;
    end
`endif

    check("ram_type_zero", 32'(type_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
